// File: rtl/sd4_mac_sequencer.sv
// ============================================================================
// sd4_mac_sequencer
// ----------------------------------------------------------------------------
// Job-level controller for the SD4 MAC pipeline. On an accepted start it
// fetches num_windows image/weight windows from the operand buffers, one per
// cycle, and presents each one on the registered MAC input. It follows every
// live window through the fixed-latency pipeline so that it can mark the
// first and last accumulator results of the job. It also reports busy/done
// to the layer-level controller.
//
// Parameters
//   ADDR_W      operand buffer address width
//   CNT_W       width of the window count
//   PIPE_DEPTH  cycles from mac_in_valid to mac_out_valid (must be >= 1)
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   start          job start pulse, only looked at while idle
//   num_windows    windows in the job, captured with start
//   base_addr      first operand buffer address, captured with start
//   exp_bias_cfg   exponent bias for the job, captured with start
//   hold           stall request; only blocks new buffer reads
//   rd_en/rd_addr  operand buffer read strobe and address
//   rd_img/rd_wgt  buffer read data, valid the cycle after rd_en
//   mac_image      registered image window to the MAC
//   mac_weight     registered SD4 weight window to the MAC
//   mac_exp_bias   job exponent bias, constant for the whole job
//   mac_in_valid   mac_image/mac_weight carry a live window
//   mac_out_valid  MAC result for a live window is present
//   acc_clear      marks the first result of the job
//   acc_last       marks the final result of the job
//   busy           job in progress (cycle after start through the done cycle)
//   done           one-cycle pulse at job end
//
// Optional feature (macro SEQ_PERF_CNT_EN)
//   perf_busy_cyc  saturating count of cycles with busy high
//   perf_hold_cyc  saturating count of issue cycles blocked by hold
//   Both clear on reset and on an accepted start. Without the macro these
//   ports and their counters do not exist.
// ============================================================================
module sd4_mac_sequencer #(
    parameter int ADDR_W     = 8,
    parameter int CNT_W      = 8,
    parameter int PIPE_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_windows,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [4:0]        exp_bias_cfg,
    input  logic              hold,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [71:0]       rd_img,
    input  logic [35:0]       rd_wgt,
    output logic [71:0]       mac_image,
    output logic [35:0]       mac_weight,
    output logic [4:0]        mac_exp_bias,
    output logic              mac_in_valid,
    output logic              mac_out_valid,
    output logic              acc_clear,
    output logic              acc_last,
    output logic              busy,
    output logic              done
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [15:0]       perf_busy_cyc,
    output logic [15:0]       perf_hold_cyc
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  num_r;
    logic [ADDR_W-1:0] base_r;
    logic [CNT_W-1:0]  issued;
    logic [CNT_W-1:0]  result_cnt;
    logic [CNT_W-1:0]  result_cnt_next;
    logic              start_accept;
    logic              rd_en_d1;
    logic [PIPE_DEPTH-1:0] valid_sr;

    // start is only honoured while idle; in every other state it is dropped.
    assign start_accept = (state == IDLE) && start;

    // Results seen so far including the one on the pipe output this cycle,
    // so DRAIN can leave on the same cycle as the final result.
    assign result_cnt_next = mac_out_valid ? (result_cnt + CNT_ONE) : result_cnt;

    // Next-state and control outputs. busy stays high through the DONE cycle,
    // so a zero-window job still shows exactly one busy cycle.
    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        rd_addr    = base_r + ADDR_W'(issued);
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (num_windows == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                busy = 1'b1;
                if (!hold && (issued < num_r)) begin
                    rd_en = 1'b1;
                    if (issued == (num_r - CNT_ONE)) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (result_cnt_next == num_r) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Job parameters are captured once per accepted start and held until the
    // next one, which keeps mac_exp_bias stable across the whole job.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            num_r        <= '0;
            base_r       <= '0;
            mac_exp_bias <= '0;
        end else if (start_accept) begin
            num_r        <= num_windows;
            base_r       <= base_addr;
            mac_exp_bias <= exp_bias_cfg;
        end
    end

    // Issue counter; the address adder wraps naturally at 2^ADDR_W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issued <= '0;
        end else if (start_accept) begin
            issued <= '0;
        end else if (rd_en) begin
            issued <= issued + CNT_ONE;
        end
    end

    // Buffer data arrives the cycle after rd_en; it is registered at the end
    // of that cycle so the window reaches the MAC two cycles after the read.
    // The data registers keep their last value between live windows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_en_d1     <= 1'b0;
            mac_in_valid <= 1'b0;
            mac_image    <= '0;
            mac_weight   <= '0;
        end else begin
            rd_en_d1     <= rd_en;
            mac_in_valid <= rd_en_d1;
            if (rd_en_d1) begin
                mac_image  <= rd_img;
                mac_weight <= rd_wgt;
            end
        end
    end

    // Valid tracking through the MAC pipeline. This runs freely and is not
    // gated by hold, because hold only stalls new reads.
    generate
        if (PIPE_DEPTH == 1) begin : g_sr_one
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    valid_sr <= '0;
                end else begin
                    valid_sr <= mac_in_valid;
                end
            end
        end else begin : g_sr_many
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    valid_sr <= '0;
                end else begin
                    valid_sr <= {valid_sr[PIPE_DEPTH-2:0], mac_in_valid};
                end
            end
        end
    endgenerate

    assign mac_out_valid = valid_sr[PIPE_DEPTH-1];

    // Result counter used to frame the accumulator.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_cnt <= '0;
        end else if (start_accept) begin
            result_cnt <= '0;
        end else begin
            result_cnt <= result_cnt_next;
        end
    end

    // With a single-window job both markers land on the same result.
    assign acc_clear = mac_out_valid && (result_cnt == '0);
    assign acc_last  = mac_out_valid && (result_cnt == (num_r - CNT_ONE));

`ifdef SEQ_PERF_CNT_EN
    // Saturating performance counters, restarted by each accepted start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_busy_cyc <= '0;
            perf_hold_cyc <= '0;
        end else if (start_accept) begin
            perf_busy_cyc <= '0;
            perf_hold_cyc <= '0;
        end else begin
            if (busy && (perf_busy_cyc != 16'hFFFF)) begin
                perf_busy_cyc <= perf_busy_cyc + 16'd1;
            end
            if ((state == ISSUE) && hold && (perf_hold_cyc != 16'hFFFF)) begin
                perf_hold_cyc <= perf_hold_cyc + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sd4_mac_sequencer.sv
// ============================================================================
// tb_sd4_mac_sequencer
// ----------------------------------------------------------------------------
// Scoreboard bench for sd4_mac_sequencer. For every job the stimulus task works
// out, from the job rules, which cycle each buffer read, MAC input, MAC result
// and done pulse should appear in, and what it should carry. It then queues
// those events. A monitor on the falling edge pops the events as the DUT
// presents them and compares them. An operand buffer model returns random
// window contents one cycle after each read.
// ============================================================================
module tb_sd4_mac_sequencer;

    localparam int ADDR_W     = 8;
    localparam int CNT_W      = 8;
    localparam int PIPE_DEPTH = 4;

    typedef struct {
        int          cyc;
        logic [71:0] a;
        logic [71:0] b;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  num_windows;
    logic [7:0]  base_addr;
    logic [4:0]  exp_bias_cfg;
    logic        hold;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [71:0] rd_img;
    logic [35:0] rd_wgt;
    logic [71:0] mac_image;
    logic [35:0] mac_weight;
    logic [4:0]  mac_exp_bias;
    logic        mac_in_valid;
    logic        mac_out_valid;
    logic        acc_clear;
    logic        acc_last;
    logic        busy;
    logic        done;
`ifdef SEQ_PERF_CNT_EN
    logic [15:0] perf_busy_cyc;
    logic [15:0] perf_hold_cyc;
`endif

    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          busy_lo = 1;
    int          busy_hi = 0;
    logic [4:0]  job_bias = '0;

    logic [71:0] img_mem [256];
    logic [35:0] wgt_mem [256];

    ev_t q_rd[$];
    ev_t q_in[$];
    ev_t q_out[$];
    ev_t q_done[$];

    logic        rd_en_s;
    logic [7:0]  addr_s;

    sd4_mac_sequencer #(
        .ADDR_W     (ADDR_W),
        .CNT_W      (CNT_W),
        .PIPE_DEPTH (PIPE_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .num_windows   (num_windows),
        .base_addr     (base_addr),
        .exp_bias_cfg  (exp_bias_cfg),
        .hold          (hold),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_img        (rd_img),
        .rd_wgt        (rd_wgt),
        .mac_image     (mac_image),
        .mac_weight    (mac_weight),
        .mac_exp_bias  (mac_exp_bias),
        .mac_in_valid  (mac_in_valid),
        .mac_out_valid (mac_out_valid),
        .acc_clear     (acc_clear),
        .acc_last      (acc_last),
        .busy          (busy),
        .done          (done)
`ifdef SEQ_PERF_CNT_EN
        ,
        .perf_busy_cyc (perf_busy_cyc),
        .perf_hold_cyc (perf_hold_cyc)
`endif
    );

    // 10 ns clock and a cycle counter advanced on every rising edge.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Operand buffer model: a read seen in one cycle returns memory contents
    // during the next cycle; otherwise the data bus carries junk.
    always @(negedge clk) begin
        rd_en_s = rd_en;
        addr_s  = rd_addr;
    end

    always @(posedge clk) begin
        logic [95:0] junk;
        #1;
        junk = {$urandom(), $urandom(), $urandom()};
        if (rd_en_s) begin
            rd_img = img_mem[addr_s];
            rd_wgt = wgt_mem[addr_s];
        end else begin
            rd_img = junk[71:0];
            rd_wgt = junk[95:60];
        end
    end

    // Monitor: retire overdue events as misses, then match each DUT output
    // against the oldest queued event of its kind.
    always @(negedge clk) begin
        ev_t e;
        while (q_rd.size() > 0 && q_rd[0].cyc < cyc) begin
            checkOutput("rd_en_missing", 72'(cyc), 72'(q_rd[0].cyc));
            void'(q_rd.pop_front());
        end
        while (q_in.size() > 0 && q_in[0].cyc < cyc) begin
            checkOutput("mac_in_missing", 72'(cyc), 72'(q_in[0].cyc));
            void'(q_in.pop_front());
        end
        while (q_out.size() > 0 && q_out[0].cyc < cyc) begin
            checkOutput("mac_out_missing", 72'(cyc), 72'(q_out[0].cyc));
            void'(q_out.pop_front());
        end
        while (q_done.size() > 0 && q_done[0].cyc < cyc) begin
            checkOutput("done_missing", 72'(cyc), 72'(q_done[0].cyc));
            void'(q_done.pop_front());
        end

        if (rd_en) begin
            if (q_rd.size() == 0) begin
                checkOutput("rd_en_unexpected", 72'(rd_en), 72'd0);
            end else begin
                e = q_rd.pop_front();
                checkOutput("rd_cycle", 72'(cyc), 72'(e.cyc));
                checkOutput("rd_addr", 72'(rd_addr), e.a);
            end
        end

        if (mac_in_valid) begin
            if (q_in.size() == 0) begin
                checkOutput("mac_in_unexpected", 72'(mac_in_valid), 72'd0);
            end else begin
                e = q_in.pop_front();
                checkOutput("mac_in_cycle", 72'(cyc), 72'(e.cyc));
                checkOutput("mac_image", mac_image, e.a);
                checkOutput("mac_weight", 72'(mac_weight), 72'(e.b[35:0]));
                checkOutput("mac_in_bias", 72'(mac_exp_bias), 72'(e.b[40:36]));
            end
        end

        if (mac_out_valid) begin
            if (q_out.size() == 0) begin
                checkOutput("mac_out_unexpected", 72'(mac_out_valid), 72'd0);
            end else begin
                e = q_out.pop_front();
                checkOutput("mac_out_cycle", 72'(cyc), 72'(e.cyc));
                checkOutput("acc_clear_last", 72'({acc_clear, acc_last}), e.a);
            end
        end else begin
            checkOutput("acc_idle", 72'({acc_clear, acc_last}), 72'd0);
        end

        if (done) begin
            if (q_done.size() == 0) begin
                checkOutput("done_unexpected", 72'(done), 72'd0);
            end else begin
                e = q_done.pop_front();
                checkOutput("done_cycle", 72'(cyc), 72'(e.cyc));
            end
        end

        checkOutput("busy", 72'(busy), 72'((cyc >= busy_lo) && (cyc <= busy_hi)));
        if ((cyc >= busy_lo) && (cyc <= busy_hi)) begin
            checkOutput("mac_exp_bias", 72'(mac_exp_bias), 72'(job_bias));
        end
    end

    // Runs one job starting in the current (idle) cycle. The expected event
    // timeline comes from the job rules: a read in every cycle after start
    // that hold does not block, the MAC input two cycles after the read, the
    // result PIPE_DEPTH cycles after that, and done on the cycle after the
    // final result (or the cycle right after start for an empty job).
    // hmode: 0 no hold, 1 hold for two cycles after the first read, 2 random.
    // abort_at: if nonzero, reset is asserted in that cycle after start.
    // pulse_mode: 1 extra start at cycle 2 and in the done cycle, 2 random.
    task automatic applyStimulus(input int num, input logic [7:0] base, input logic [4:0] bias,
                                 input int hmode, input int abort_at, input int pulse_mode);
        bit  hq[$];
        int  s;
        int  c;
        int  issued;
        int  last_c;
        int  held;
        int  done_rel;
        ev_t e;
        s            = cyc;
        start        = 1'b1;
        num_windows  = 8'(num);
        base_addr    = base;
        exp_bias_cfg = bias;
        hold         = 1'b0;
        issued       = 0;
        c            = 0;
        last_c       = 0;
        held         = 0;
        while (issued < num) begin
            bit h;
            c++;
            case (hmode)
                1:       h = (c == 2) || (c == 3);
                2:       h = ($urandom_range(0, 3) == 0);
                default: h = 1'b0;
            endcase
            hq.push_back(h);
            if (h) begin
                held++;
            end else begin
                logic [7:0] a;
                a = base + 8'(issued);
                e.cyc = s + c;
                e.a   = 72'(a);
                e.b   = '0;
                q_rd.push_back(e);
                e.cyc = s + c + 2;
                e.a   = img_mem[a];
                e.b   = 72'({bias, wgt_mem[a]});
                q_in.push_back(e);
                e.cyc = s + c + 2 + PIPE_DEPTH;
                e.a   = 72'({issued == 0, issued == num - 1});
                e.b   = '0;
                q_out.push_back(e);
                issued++;
                last_c = c;
            end
        end
        done_rel = (num == 0) ? 1 : last_c + PIPE_DEPTH + 3;
        e.cyc = s + done_rel;
        e.a   = '0;
        e.b   = '0;
        q_done.push_back(e);
        busy_lo  = s + 1;
        busy_hi  = s + done_rel;
        job_bias = bias;
        $display("[TB] job num=%0d base=%0h bias=%0d held=%0d done expected at cycle %0d",
                 num, base, bias, held, s + done_rel);

        for (int k = 1; k <= done_rel + 1; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (k <= last_c) hold = hq[k-1];
            else             hold = 1'($urandom_range(0, 1));
            if (k == abort_at) begin
                rst = 1'b0;
                q_rd.delete();
                q_in.delete();
                q_out.delete();
                q_done.delete();
                busy_lo = 1;
                busy_hi = 0;
                hold    = 1'b0;
                @(negedge clk);
                checkOutput("rst_ctrl", 72'({rd_en, rd_addr, mac_exp_bias, mac_in_valid, mac_out_valid,
                                             acc_clear, acc_last, busy, done}), 72'd0);
                checkOutput("rst_image", mac_image, 72'd0);
                checkOutput("rst_weight", 72'(mac_weight), 72'd0);
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b1;
                repeat (20) @(posedge clk);
                #1;
                return;
            end
            if (k <= done_rel &&
                ((pulse_mode == 1 && (k == 2 || k == done_rel)) ||
                 (pulse_mode == 2 && $urandom_range(0, 5) == 0))) begin
                start        = 1'b1;
                num_windows  = 8'($urandom_range(1, 255));
                base_addr    = 8'($urandom_range(0, 255));
                exp_bias_cfg = 5'($urandom_range(0, 31));
            end
        end
        hold = 1'b0;
`ifdef SEQ_PERF_CNT_EN
        checkOutput("perf_hold_cyc", 72'(perf_hold_cyc), 72'(held));
        checkOutput("perf_busy_cyc", 72'(perf_busy_cyc), 72'(done_rel));
`endif
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            img_mem[i] = {8'($urandom()), $urandom(), $urandom()};
            wgt_mem[i] = {4'($urandom()), $urandom()};
        end
        rst          = 1'b1;
        start        = 1'b0;
        num_windows  = '0;
        base_addr    = '0;
        exp_bias_cfg = '0;
        hold         = 1'b0;
        rd_img       = '0;
        rd_wgt       = '0;
        #1 rst = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ctrl", 72'({rd_en, rd_addr, mac_exp_bias, mac_in_valid, mac_out_valid,
                                       acc_clear, acc_last, busy, done}), 72'd0);
        checkOutput("reset_image", mac_image, 72'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(10, 8'h20, 5'd7, 0, 4, 0);
        applyStimulus(5,  8'h10, 5'd3, 0, 0, 0);
        applyStimulus(3,  8'h40, 5'd9, 1, 0, 0);
        applyStimulus(0,  8'h55, 5'd1, 0, 0, 0);
        applyStimulus(1,  8'hFF, 5'd2, 0, 0, 0);
        applyStimulus(2,  8'hFF, 5'd4, 0, 0, 0);
        applyStimulus(4,  8'h80, 5'd5, 0, 0, 1);
        for (int j = 0; j < 30; j++) begin
            applyStimulus($urandom_range(0, 12), 8'($urandom_range(0, 255)),
                          5'($urandom_range(0, 31)), 2, 0, 2);
        end

        repeat (10) @(posedge clk);
        #1;
        checkOutput("queues_drained", 72'(q_rd.size() + q_in.size() + q_out.size() + q_done.size()), 72'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
